// File: rtl/sign_ext_unpacker_pkg.sv
// Shared constants, FSM encoding and width helper for the sign-extension datapath.
package sign_ext_pkg;

  // Default geometry shared by the unpacker and the sign-extension blocks
  localparam int DEF_N     = 12;
  localparam int DEF_M     = 32;
  localparam int DEF_LANES = 2;

  // Two-state sequencer: idle waiting for a beat, or emitting its fields
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Width needed to hold a field count of 0..lanes inclusive
  function automatic int clog2_cnt(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/sign_ext_unpacker_if.sv
// Packed-beat input port and sign-extended field output port, grouped as one bus.
interface sign_ext_unpacker_if
  import sign_ext_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int M     = DEF_M,
  parameter int LANES = DEF_LANES
) ();

  localparam int CW = clog2_cnt(LANES);

  // Upstream beat side
  logic                 i_valid;
  logic                 o_ready;
  logic [LANES*N-1:0]   i_data;
  logic [CW-1:0]        i_cnt;
  logic                 i_flush;

  // Downstream field side
  logic                 o_valid;
  logic                 i_ready;
  logic [M-1:0]         o_data;
  logic                 o_last;
  logic [CW-1:0]        o_lane;

  // Producer/consumer environment around the unpacker
  modport master (
    output i_valid, i_data, i_cnt, i_flush, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_lane
  );

  // The unpacker itself
  modport slave (
    input  i_valid, i_data, i_cnt, i_flush, i_ready,
    output o_ready, o_valid, o_data, o_last, o_lane
  );

endinterface

// File: rtl/sign_ext_unpacker_sext.sv
// Sign-extends one N-bit field to M bits; pass-through when the widths match.
module sign_ext_behavioral
  import sign_ext_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic [N-1:0] i_field,
  output logic [M-1:0] o_data
);

  generate
    if (M == N) begin : g_same
      assign o_data = i_field;
    end else begin : g_ext
      // Replicate the field's sign bit into the upper M-N bits
      assign o_data = {{(M - N){i_field[N-1]}}, i_field};
    end
  endgenerate

endmodule

// File: rtl/sign_ext_unpacker.sv
// Accepts packed beats of LANES signed fields and issues them one per cycle,
// each sign-extended to M bits, with full valid/ready flow control on both sides.
module sign_ext_unpacker
  import sign_ext_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int M     = DEF_M,
  parameter int LANES = DEF_LANES
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  sign_ext_unpacker_if.slave bus
);

  localparam int            CW      = clog2_cnt(LANES);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);

  state_e             r_state;
  state_e             w_state_next;
  logic [LANES*N-1:0] r_word;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      r_lane;

  logic               w_busy;
  logic               w_last;
  logic               w_ready;
  logic               w_accept;
  logic               w_xfer;
  logic [CW-1:0]      w_cnt_clamped;
  logic [N-1:0]       w_lane_fields [LANES];
  logic [N-1:0]       w_field;

  assign w_busy        = (r_state == ST_EMIT);
  // cnt is at least 1 whenever busy, so cnt-1 never underflows where it matters
  assign w_last        = w_busy && (r_lane == (r_cnt - CW'(1)));
  // Next beat may enter as the final field leaves; flush blocks any accept
  assign w_ready       = !bus.i_flush && (!w_busy || (bus.i_ready && w_last));
  assign w_accept      = bus.i_valid && w_ready;
  assign w_xfer        = w_busy && bus.i_ready;
  assign w_cnt_clamped = (bus.i_cnt > LANES_C) ? LANES_C : bus.i_cnt;

  // State register: busy flag of the sequencer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: flush wins, then accept (empty beats stay idle), then final transfer
  always_comb begin
    w_state_next = r_state;
    if (bus.i_flush) begin
      w_state_next = ST_IDLE;
    end else if (w_accept) begin
      w_state_next = (w_cnt_clamped != '0) ? ST_EMIT : ST_IDLE;
    end else if (w_xfer && w_last) begin
      w_state_next = ST_IDLE;
    end
  end

  // FSM outputs: field valid while emitting, upstream ready from the handshake rule
  always_comb begin
    bus.o_valid = w_busy;
    bus.o_ready = w_ready;
  end

  // Beat capture and lane stepping; lane returns to 0 after the last field or a flush
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word <= '0;
      r_cnt  <= '0;
      r_lane <= '0;
    end else if (bus.i_flush) begin
      r_lane <= '0;
    end else if (w_accept) begin
      r_word <= bus.i_data;
      r_cnt  <= w_cnt_clamped;
      r_lane <= '0;
    end else if (w_xfer) begin
      r_lane <= w_last ? '0 : (r_lane + CW'(1));
    end
  end

  // Split the held word into its lanes
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane_fields[gi] = r_word[gi*N +: N];
    end
  endgenerate

  // Lane mux driven only by registers, so o_data has no path from i_data
  always_comb begin
    w_field = '0;
    for (int k = 0; k < LANES; k++) begin
      if (r_lane == CW'(k)) begin
        w_field = w_lane_fields[k];
      end
    end
  end

  sign_ext_behavioral #(.N(N), .M(M)) u_sext (
    .i_field (w_field),
    .o_data  (bus.o_data)
  );

  assign bus.o_last = w_last;
  assign bus.o_lane = r_lane;

endmodule

// File: tb/tb_sign_ext_unpacker.sv
// Directed and random checks of the sign-extension unpacker (N=12, M=32, LANES=2).
module tb_sign_ext_unpacker;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  sign_ext_unpacker_if #(.N(12), .M(32), .LANES(2)) bus ();

  sign_ext_unpacker #(.N(12), .M(32), .LANES(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // One line per field transfer
  always @(posedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready)
      $display("xfer lane=%0d last=%0b data=%h", bus.o_lane, bus.o_last, bus.o_data);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 24'h800_7FF;
    bus.i_cnt   = 2'd2;
    bus.i_ready = 1'b1;
    bus.i_flush = 1'b0;
    repeat (3) tick;
    checks++;
    if ({bus.o_valid, bus.o_lane, bus.o_last, bus.o_data} !== {1'b0, 2'd0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h",
               {bus.o_valid, bus.o_lane, bus.o_last, bus.o_data}, {1'b0, 2'd0, 1'b0, 32'h0});
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst_n       = 1'b1;
    tick;
    checks++;
    if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_release: valid/ready got %b want 01", {bus.o_valid, bus.o_ready});
    end
  endtask

  task automatic test_basic;
    bus.i_valid = 1'b1;
    bus.i_data  = 24'h800_7FF;
    bus.i_cnt   = 2'd2;
    bus.i_ready = 1'b1;
    tick;
    bus.i_valid = 1'b0;
    checks++;
    if ({bus.o_valid, bus.o_lane, bus.o_last, bus.o_data} !== {1'b1, 2'd0, 1'b0, 32'h0000_07FF}) begin
      errors++;
      $display("FAIL basic_f0: got %h want %h",
               {bus.o_valid, bus.o_lane, bus.o_last, bus.o_data}, {1'b1, 2'd0, 1'b0, 32'h0000_07FF});
    end
    tick;
    checks++;
    if ({bus.o_valid, bus.o_lane, bus.o_last, bus.o_data} !== {1'b1, 2'd1, 1'b1, 32'hFFFF_F800}) begin
      errors++;
      $display("FAIL basic_f1: got %h want %h",
               {bus.o_valid, bus.o_lane, bus.o_last, bus.o_data}, {1'b1, 2'd1, 1'b1, 32'hFFFF_F800});
    end
    tick;
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: o_valid got %b want 0", bus.o_valid);
    end
  endtask

  task automatic test_back_to_back;
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 24'hFFF_001;
    bus.i_cnt   = 2'd2;
    tick;
    bus.i_data  = 24'h7FF_800;
    checks++;
    if ({bus.o_valid, bus.o_data} !== {1'b1, 32'h0000_0001}) begin
      errors++;
      $display("FAIL b2b_f0: got %h want %h", {bus.o_valid, bus.o_data}, {1'b1, 32'h0000_0001});
    end
    tick;
    checks++;
    if ({bus.o_valid, bus.o_last, bus.o_ready, bus.o_data} !== {3'b111, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL b2b_f1: got %h want %h",
               {bus.o_valid, bus.o_last, bus.o_ready, bus.o_data}, {3'b111, 32'hFFFF_FFFF});
    end
    tick;
    bus.i_valid = 1'b0;
    checks++;
    if ({bus.o_valid, bus.o_lane, bus.o_data} !== {1'b1, 2'd0, 32'hFFFF_F800}) begin
      errors++;
      $display("FAIL b2b_f2: got %h want %h",
               {bus.o_valid, bus.o_lane, bus.o_data}, {1'b1, 2'd0, 32'hFFFF_F800});
    end
    tick;
    checks++;
    if ({bus.o_valid, bus.o_lane, bus.o_data} !== {1'b1, 2'd1, 32'h0000_07FF}) begin
      errors++;
      $display("FAIL b2b_f3: got %h want %h",
               {bus.o_valid, bus.o_lane, bus.o_data}, {1'b1, 2'd1, 32'h0000_07FF});
    end
    tick;
  endtask

  task automatic test_backpressure;
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 24'h000_FFF;
    bus.i_cnt   = 2'd2;
    tick;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({bus.o_valid, bus.o_ready, bus.o_lane, bus.o_last, bus.o_data} !==
          {2'b10, 2'd0, 1'b0, 32'hFFFF_FFFF}) begin
        errors++;
        $display("FAIL bp_hold%0d: got %h want %h", c,
                 {bus.o_valid, bus.o_ready, bus.o_lane, bus.o_last, bus.o_data},
                 {2'b10, 2'd0, 1'b0, 32'hFFFF_FFFF});
      end
      tick;
    end
    bus.i_ready = 1'b1;
    tick;
    checks++;
    if ({bus.o_valid, bus.o_lane, bus.o_last, bus.o_data} !== {1'b1, 2'd1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL bp_f1: got %h want %h",
               {bus.o_valid, bus.o_lane, bus.o_last, bus.o_data}, {1'b1, 2'd1, 1'b1, 32'h0});
    end
    tick;
  endtask

  task automatic test_partial;
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 24'hABC_800;
    bus.i_cnt   = 2'd1;
    tick;
    bus.i_valid = 1'b0;
    checks++;
    if ({bus.o_valid, bus.o_lane, bus.o_last, bus.o_data} !== {1'b1, 2'd0, 1'b1, 32'hFFFF_F800}) begin
      errors++;
      $display("FAIL part_cnt1: got %h want %h",
               {bus.o_valid, bus.o_lane, bus.o_last, bus.o_data}, {1'b1, 2'd0, 1'b1, 32'hFFFF_F800});
    end
    tick;
    bus.i_valid = 1'b1;
    bus.i_data  = 24'h123_456;
    bus.i_cnt   = 2'd0;
    #1;
    checks++;
    if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
      errors++;
      $display("FAIL part_cnt0_ready: got %b want 01", {bus.o_valid, bus.o_ready});
    end
    tick;
    bus.i_valid = 1'b0;
    tick;
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL part_cnt0_novalid: o_valid got %b want 0", bus.o_valid);
    end
    bus.i_valid = 1'b1;
    bus.i_cnt   = 2'd3;
    tick;
    bus.i_valid = 1'b0;
    checks++;
    if ({bus.o_valid, bus.o_lane, bus.o_last, bus.o_data} !== {1'b1, 2'd0, 1'b0, 32'h0000_0456}) begin
      errors++;
      $display("FAIL part_cnt3_f0: got %h want %h",
               {bus.o_valid, bus.o_lane, bus.o_last, bus.o_data}, {1'b1, 2'd0, 1'b0, 32'h0000_0456});
    end
    tick;
    checks++;
    if ({bus.o_valid, bus.o_lane, bus.o_last, bus.o_data} !== {1'b1, 2'd1, 1'b1, 32'h0000_0123}) begin
      errors++;
      $display("FAIL part_cnt3_f1: got %h want %h",
               {bus.o_valid, bus.o_lane, bus.o_last, bus.o_data}, {1'b1, 2'd1, 1'b1, 32'h0000_0123});
    end
    tick;
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL part_cnt3_end: o_valid got %b want 0", bus.o_valid);
    end
  endtask

  task automatic test_flush;
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 24'h800_001;
    bus.i_cnt   = 2'd2;
    tick;
    checks++;
    if ({bus.o_valid, bus.o_data} !== {1'b1, 32'h0000_0001}) begin
      errors++;
      $display("FAIL flush_pre: got %h want %h", {bus.o_valid, bus.o_data}, {1'b1, 32'h0000_0001});
    end
    bus.i_ready = 1'b0;
    bus.i_flush = 1'b1;
    bus.i_data  = 24'h555_555;
    #1;
    checks++;
    if (bus.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: o_ready got %b want 0", bus.o_ready);
    end
    tick;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    #1;
    checks++;
    if ({bus.o_valid, bus.o_ready, bus.o_lane} !== {2'b01, 2'd0}) begin
      errors++;
      $display("FAIL flush_after: valid/ready/lane got %h want %h",
               {bus.o_valid, bus.o_ready, bus.o_lane}, {2'b01, 2'd0});
    end
    tick;
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_lane1: o_valid got %b want 0", bus.o_valid);
    end
  endtask

  task automatic test_async_reset;
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 24'h7FF_FFF;
    bus.i_cnt   = 2'd2;
    tick;
    bus.i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_valid, bus.o_data} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL arst_immediate: got %h want %h", {bus.o_valid, bus.o_data}, {1'b0, 32'h0});
    end
    @(negedge clk);
    rst_n       = 1'b1;
    bus.i_ready = 1'b1;
    tick;
    tick;
    checks++;
    if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
      errors++;
      $display("FAIL arst_release: valid/ready got %b want 01", {bus.o_valid, bus.o_ready});
    end
  endtask

  task automatic test_random;
    logic [34:0]        exp_q [$];
    logic [34:0]        e;
    logic [35:0]        prev_obs;
    logic               hold_prev;
    logic               acc;
    logic signed [11:0] fld;
    logic signed [31:0] sx;
    int                 cn;
    int                 sent;
    int                 cyc;
    hold_prev = 1'b0;
    prev_obs  = '0;
    sent      = 0;
    cyc       = 0;
    bus.i_valid = 1'b0;
    while ((sent < 200 || exp_q.size() != 0 || bus.o_valid) && cyc < 20000) begin
      cyc++;
      bus.i_ready = ($urandom_range(0, 3) != 0);
      if (!bus.i_valid && sent < 200) begin
        bus.i_data  = 24'($urandom);
        bus.i_cnt   = 2'($urandom_range(0, 3));
        bus.i_valid = 1'b1;
      end
      #1;
      if (hold_prev) begin
        checks++;
        if ({bus.o_valid, bus.o_lane, bus.o_last, bus.o_data} !== prev_obs) begin
          errors++;
          $display("FAIL rnd_hold: got %h want %h",
                   {bus.o_valid, bus.o_lane, bus.o_last, bus.o_data}, prev_obs);
        end
      end
      if (bus.o_valid && bus.i_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_field: got %h want none", {bus.o_lane, bus.o_last, bus.o_data});
        end else begin
          e = exp_q.pop_front();
          if ({bus.o_lane, bus.o_last, bus.o_data} !== e) begin
            errors++;
            $display("FAIL rnd_field: got %h want %h", {bus.o_lane, bus.o_last, bus.o_data}, e);
          end
        end
      end
      hold_prev = bus.o_valid && !bus.i_ready;
      prev_obs  = {bus.o_valid, bus.o_lane, bus.o_last, bus.o_data};
      acc       = bus.i_valid && bus.o_ready;
      if (acc) begin
        cn = (int'(bus.i_cnt) > 2) ? 2 : int'(bus.i_cnt);
        for (int k = 0; k < cn; k++) begin
          fld = bus.i_data[k*12 +: 12];
          sx  = fld;
          exp_q.push_back({2'(k), (k == cn - 1), sx});
        end
        sent++;
      end
      tick;
      if (acc) bus.i_valid = 1'b0;
    end
    checks++;
    if (cyc >= 20000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rnd_drain: cycles=%0d left=%0d want fewer than 20000 and 0", cyc, exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_backpressure;
    test_partial;
    test_flush;
    test_async_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
